screen_sequencer: RTL and testbench

Top-level screen controller for the Snake display path. It decides which full-screen image the pixel drawer sweeps: title, black clear, title flash, or game-over fill. It runs every sweep to completion and hands the VGA adapter a plot strobe. It sits between the game FSM (start / game-over events) and the drawer, and grants the display to the game logic only while a game is in progress.

---
 rtl/screen_sequencer.sv | 139 +++++++++++++
 tb/tb_screen_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// Screen sequencer for the Snake display path: picks which full-screen image the
// pixel drawer sweeps, runs each sweep to completion and hands out the plot strobe.
module screen_sequencer #(
    parameter int PIXELS      = 19200,
    parameter int FLASH_TICKS = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic game_over,
    input  logic frame_tick,
    output logic show_title,
    output logic show_black,
    output logic show_game_over,
    output logic flash,
    output logic draw_rst_n,
    output logic plot,
    output logic game_enable,
    output logic busy
);

    localparam int CW = 15;
    localparam int TW = $clog2(FLASH_TICKS + 1);
    localparam logic [CW-1:0] LAST_PIXEL = CW'(PIXELS - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(FLASH_TICKS - 1);

    typedef enum logic [2:0] {BOOT, PREP, SWEEP, TITLE_IDLE, PLAYING, GO_IDLE} state_t;
    typedef enum logic [1:0] {M_TITLE, M_FLASH, M_CLEAR, M_GAMEOVER} mode_t;

    state_t state, state_nxt, next_after, next_after_nxt;
    mode_t mode, mode_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [TW-1:0] ticks, ticks_nxt;
    logic phase, phase_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= BOOT;
            next_after <= TITLE_IDLE;
            mode       <= M_TITLE;
            count      <= '0;
            ticks      <= '0;
            phase      <= 1'b0;
        end else begin
            state      <= state_nxt;
            next_after <= next_after_nxt;
            mode       <= mode_nxt;
            count      <= count_nxt;
            ticks      <= ticks_nxt;
            phase      <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        next_after_nxt = next_after;
        mode_nxt       = mode;
        count_nxt      = count;
        ticks_nxt      = ticks;
        phase_nxt      = phase;
        case (state)
            BOOT: begin
                state_nxt      = PREP;
                mode_nxt       = M_TITLE;
                next_after_nxt = TITLE_IDLE;
            end
            PREP: begin
                count_nxt = '0;
                state_nxt = SWEEP;
            end
            SWEEP: begin
                if (count == LAST_PIXEL) state_nxt = next_after;
                else                     count_nxt = count + 1'b1;
            end
            TITLE_IDLE: begin
                // start wins over a flash toggle landing on the same cycle
                if (start) begin
                    state_nxt      = PREP;
                    mode_nxt       = M_CLEAR;
                    next_after_nxt = PLAYING;
                    ticks_nxt      = '0;
                    phase_nxt      = 1'b0;
                end else if (frame_tick) begin
                    if (ticks == LAST_TICK) begin
                        ticks_nxt      = '0;
                        phase_nxt      = ~phase;
                        state_nxt      = PREP;
                        mode_nxt       = phase ? M_TITLE : M_FLASH;
                        next_after_nxt = TITLE_IDLE;
                    end else begin
                        ticks_nxt = ticks + 1'b1;
                    end
                end
            end
            PLAYING: begin
                if (game_over) begin
                    state_nxt      = PREP;
                    mode_nxt       = M_GAMEOVER;
                    next_after_nxt = GO_IDLE;
                end
            end
            GO_IDLE: begin
                if (start) begin
                    state_nxt      = PREP;
                    mode_nxt       = M_CLEAR;
                    next_after_nxt = TITLE_IDLE;
                    ticks_nxt      = '0;
                    phase_nxt      = 1'b0;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // CLEAR also raises show_title so the drawer keeps advancing its address
    always_comb begin
        show_title     = 1'b0;
        show_black     = 1'b0;
        show_game_over = 1'b0;
        flash          = 1'b0;
        busy           = (state == PREP) || (state == SWEEP);
        plot           = (state == SWEEP);
        draw_rst_n     = (state == SWEEP);
        game_enable    = (state == PLAYING);
        if (busy) begin
            case (mode)
                M_TITLE:    show_title = 1'b1;
                M_FLASH:    flash = 1'b1;
                M_CLEAR: begin
                    show_title = 1'b1;
                    show_black = 1'b1;
                end
                M_GAMEOVER: show_game_over = 1'b1;
                default:    show_title = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: randomized events checked every cycle against an
// abstract sweep/idle model, plus directed collision and reset scenarios.
module tb_screen_sequencer;

    localparam int P  = 300;
    localparam int FT = 6;

    localparam int K_TITLE = 0, K_FLASH = 1, K_CLEAR = 2, K_GO = 3;
    localparam int I_TITLE = 0, I_PLAY = 1, I_GO = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, game_over = 1'b0, frame_tick = 1'b0;
    logic show_title, show_black, show_game_over, flash;
    logic draw_rst_n, plot, game_enable, busy;

    int total = 0;
    int bad = 0;

    // model: sweep position 0 is the prep cycle, 1..P are the pixel cycles
    bit m_boot = 1'b1;
    bit m_in_sweep = 1'b0;
    int m_pos = 0;
    int m_kind = K_TITLE;
    int m_after = I_TITLE;
    int m_idle = I_TITLE;
    int m_ticks = 0;
    bit m_phase = 1'b0;

    screen_sequencer #(.PIXELS(P), .FLASH_TICKS(FT)) dut (
        .clk(clk), .rst(rst), .start(start), .game_over(game_over),
        .frame_tick(frame_tick), .show_title(show_title), .show_black(show_black),
        .show_game_over(show_game_over), .flash(flash), .draw_rst_n(draw_rst_n),
        .plot(plot), .game_enable(game_enable), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dut_vec();
        return {show_title, show_black, show_game_over, flash,
                draw_rst_n, plot, game_enable, busy};
    endfunction

    function automatic logic [7:0] model_vec();
        logic [7:0] v;
        v = 8'b0;
        if (m_boot) return v;
        if (m_in_sweep) begin
            v[7] = (m_kind == K_TITLE) || (m_kind == K_CLEAR);
            v[6] = (m_kind == K_CLEAR);
            v[5] = (m_kind == K_GO);
            v[4] = (m_kind == K_FLASH);
            v[3] = (m_pos > 0);
            v[2] = (m_pos > 0);
            v[0] = 1'b1;
        end else begin
            v[1] = (m_idle == I_PLAY);
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic begin_sweep(input int kind, input int after);
        m_in_sweep = 1'b1;
        m_pos = 0;
        m_kind = kind;
        m_after = after;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit g, input bit f);
        if (!r) begin
            m_boot = 1'b1;
            m_in_sweep = 1'b0;
            m_ticks = 0;
            m_phase = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            begin_sweep(K_TITLE, I_TITLE);
        end else if (m_in_sweep) begin
            if (m_pos == P) begin
                m_in_sweep = 1'b0;
                m_idle = m_after;
            end else begin
                m_pos++;
            end
        end else if (m_idle == I_TITLE) begin
            if (s) begin
                m_ticks = 0;
                m_phase = 1'b0;
                begin_sweep(K_CLEAR, I_PLAY);
            end else if (f) begin
                if (m_ticks + 1 == FT) begin
                    m_ticks = 0;
                    m_phase = ~m_phase;
                    begin_sweep(m_phase ? K_FLASH : K_TITLE, I_TITLE);
                end else begin
                    m_ticks++;
                end
            end
        end else if (m_idle == I_PLAY) begin
            if (g) begin_sweep(K_GO, I_GO);
        end else begin
            if (s) begin
                m_ticks = 0;
                m_phase = 1'b0;
                begin_sweep(K_CLEAR, I_TITLE);
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit g, input bit f);
        rst = r;
        start = s;
        game_over = g;
        frame_tick = f;
        @(posedge clk);
        model_edge(r, s, g, f);
        #1;
        checkOutput("cycle", dut_vec(), model_vec());
    endtask

    // random frame ticks everywhere; start/game_over only while a sweep should drop them
    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            bit f, s, g;
            f = ($urandom % 4) == 0;
            s = m_in_sweep && (($urandom % 6) == 0);
            g = m_in_sweep && (($urandom % 6) == 0);
            applyStimulus(1'b1, s, g, f);
        end
    endtask

    initial begin
        int busy_cnt, plot_cnt, guard;
        bit found;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", dut_vec(), 8'b0);

        busy_cnt = 0;
        plot_cnt = 0;
        guard = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            if (busy) busy_cnt++;
            if (plot) plot_cnt++;
            guard++;
        end while ((busy || guard < 2) && guard < P + 20);
        checkOutput("boot_busy_len", 8'(busy_cnt), 8'(P + 1));
        checkOutput("boot_plot_len", 8'(plot_cnt), 8'(P));
        checkOutput("title_idle_outputs", dut_vec(), 8'b0);

        noise(4 * (P + 1));

        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (!m_boot && !m_in_sweep && m_idle == I_TITLE && m_ticks == FT - 1) found = 1'b1;
            else noise(1);
        end
        checkOutput("collision_reachable", 8'(found), 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("collision_clear", {4'b0, show_black, flash, busy, draw_rst_n}, 8'b0000_1010);

        noise(P + 3);
        checkOutput("playing_enable", {7'b0, game_enable}, 8'd1);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("gameover_prep", {4'b0, game_enable, busy, show_game_over, draw_rst_n}, 8'b0000_0110);

        noise(P - 5);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'($urandom % 2));
        noise(P + 10);
        checkOutput("back_to_title", {7'b0, busy}, 8'd0);

        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (m_in_sweep && m_pos == P / 2) found = 1'b1;
            else noise(1);
        end
        checkOutput("midsweep_reachable", 8'(found), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midsweep_reset", {6'b0, plot, busy}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("after_reset_prep", dut_vec(), 8'b1000_0001);
        noise(P + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
